// File: rtl/verificador_de_senha.sv
// Password checker for a keypad lock: compares a completed keypad entry
// against a reprogrammable user password, drives unlock/error strobes,
// counts consecutive failures, locks out after too many, and lets the
// user password be replaced after presenting the master password.
module verificador_de_senha #(
    parameter logic [79:0] SENHA_PADRAO    = 80'hFFFF_FFFF_FFFF_FFFF_1234,
    parameter logic [79:0] SENHA_MESTRE    = 80'hFFFF_FFFF_FFFF_FFF9_9999,
    parameter int          MAX_TENTATIVAS  = 3,
    parameter int          BLOQUEIO_CICLOS = 1000,
    parameter int          DESTRAVA_CICLOS = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [79:0] digitos_value,
    input  logic        digitos_valid,
    input  logic        prog_req,
    output logic        teclado_en,
    output logic        destrava,
    output logic        senha_erro,
    output logic        bloqueado,
    output logic        prog_ativo,
    output logic [1:0]  tentativas
);

    localparam int MAX_CICLOS = (BLOQUEIO_CICLOS > DESTRAVA_CICLOS) ? BLOQUEIO_CICLOS
                                                                     : DESTRAVA_CICLOS;
    localparam int CNT_W = (MAX_CICLOS > 1) ? $clog2(MAX_CICLOS + 1) : 1;

    // Counters are loaded with duration-1 so the indication lasts exactly
    // the requested number of cycles; a zero duration degrades to one cycle.
    localparam logic [CNT_W-1:0] CARGA_DESTRAVA =
        CNT_W'((DESTRAVA_CICLOS > 0) ? DESTRAVA_CICLOS - 1 : 0);
    localparam logic [CNT_W-1:0] CARGA_BLOQUEIO =
        CNT_W'((BLOQUEIO_CICLOS > 0) ? BLOQUEIO_CICLOS - 1 : 0);
    localparam logic [1:0] TENT_MAX = 2'(MAX_TENTATIVAS);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ABRE,
        ERRO,
        BLOQUEIO,
        PROG_NOVA,
        PROG_GRAVA
    } estado_t;

    typedef enum logic [1:0] {
        CL_CANCEL,
        CL_TIMEOUT,
        CL_OK,
        CL_MALF
    } classe_t;

    estado_t          estado;
    logic [79:0]      entrada;
    logic [79:0]      senha;
    logic [CNT_W-1:0] cnt;
    classe_t          classe;
    logic             aceita;

    // Newest key sits in the lowest nibble, so a well-formed entry is a run
    // of 4..12 decimal digits starting at nibble 0 with 4'hF padding above.
    function automatic classe_t classifica(input logic [79:0] v);
        logic       todos_b;
        logic       todos_e;
        logic       prefixo;
        logic       padding_ok;
        logic [3:0] nib;
        int         comp;
        todos_b    = 1'b1;
        todos_e    = 1'b1;
        prefixo    = 1'b1;
        padding_ok = 1'b1;
        comp       = 0;
        for (int i = 0; i < 20; i++) begin
            nib = v[4*i +: 4];
            if (nib != 4'hB) todos_b = 1'b0;
            if (nib != 4'hE) todos_e = 1'b0;
            if (prefixo && (nib <= 4'd9)) begin
                comp = comp + 1;
            end else begin
                prefixo = 1'b0;
                if (nib != 4'hF) padding_ok = 1'b0;
            end
        end
        if (todos_b)                                 return CL_CANCEL;
        else if (todos_e)                            return CL_TIMEOUT;
        else if (padding_ok && comp >= 4 && comp <= 12) return CL_OK;
        else                                         return CL_MALF;
    endfunction

    // Entries are taken only while the keypad is enabled; a falling prog_req
    // in PROG_NOVA wins over a simultaneous entry.
    always_comb begin
        aceita = digitos_valid &&
                 ((estado == IDLE) || (estado == PROG_NOVA && prog_req));
        classe = classifica(entrada);
    end

    // Entry capture register; pure data, so it carries no reset.
    always_ff @(posedge clk) begin
        if (aceita) entrada <= digitos_value;
    end

    // Main controller: state, duration counter, stored password and all outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado     <= IDLE;
            teclado_en <= 1'b1;
            destrava   <= 1'b0;
            senha_erro <= 1'b0;
            bloqueado  <= 1'b0;
            prog_ativo <= 1'b0;
            tentativas <= 2'd0;
            cnt        <= '0;
            senha      <= SENHA_PADRAO;
        end else begin
            case (estado)
                IDLE: begin
                    // Clears the one-cycle acknowledgement left by PROG_GRAVA.
                    destrava   <= 1'b0;
                    senha_erro <= 1'b0;
                    if (aceita) begin
                        estado     <= CHECK;
                        teclado_en <= 1'b0;
                    end
                end
                CHECK: begin
                    if (classe == CL_CANCEL || classe == CL_TIMEOUT) begin
                        estado     <= IDLE;
                        teclado_en <= 1'b1;
                    end else if (!prog_req && entrada == senha) begin
                        estado     <= ABRE;
                        tentativas <= 2'd0;
                        destrava   <= 1'b1;
                        cnt        <= CARGA_DESTRAVA;
                    end else if (prog_req && entrada == SENHA_MESTRE) begin
                        estado     <= PROG_NOVA;
                        prog_ativo <= 1'b1;
                        teclado_en <= 1'b1;
                    end else begin
                        estado     <= ERRO;
                        senha_erro <= 1'b1;
                        cnt        <= CARGA_DESTRAVA;
                        if (tentativas < TENT_MAX) tentativas <= tentativas + 2'd1;
                    end
                end
                ABRE: begin
                    if (cnt == '0) begin
                        estado     <= IDLE;
                        destrava   <= 1'b0;
                        teclado_en <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ERRO: begin
                    if (cnt == '0) begin
                        senha_erro <= 1'b0;
                        if (tentativas >= TENT_MAX) begin
                            estado    <= BLOQUEIO;
                            bloqueado <= 1'b1;
                            cnt       <= CARGA_BLOQUEIO;
                        end else begin
                            estado     <= IDLE;
                            teclado_en <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                BLOQUEIO: begin
                    if (cnt == '0) begin
                        estado     <= IDLE;
                        bloqueado  <= 1'b0;
                        tentativas <= 2'd0;
                        teclado_en <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                PROG_NOVA: begin
                    if (!prog_req) begin
                        estado     <= IDLE;
                        prog_ativo <= 1'b0;
                    end else if (aceita) begin
                        estado     <= PROG_GRAVA;
                        teclado_en <= 1'b0;
                    end
                end
                PROG_GRAVA: begin
                    // Rejected new passwords are not counted as failed attempts.
                    if (classe == CL_OK) begin
                        senha    <= entrada;
                        destrava <= 1'b1;
                    end else begin
                        senha_erro <= 1'b1;
                    end
                    estado     <= IDLE;
                    prog_ativo <= 1'b0;
                    teclado_en <= 1'b1;
                end
                default: begin
                    estado     <= IDLE;
                    teclado_en <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_verificador_de_senha.sv
// Directed testbench for verificador_de_senha with default parameters.
module tb_verificador_de_senha;

    localparam logic [79:0] P_1234   = 80'hFFFF_FFFF_FFFF_FFFF_1234;
    localparam logic [79:0] P_1111   = 80'hFFFF_FFFF_FFFF_FFFF_1111;
    localparam logic [79:0] P_MESTRE = 80'hFFFF_FFFF_FFFF_FFF9_9999;
    localparam logic [79:0] P_NOVA   = 80'hFFFF_FFFF_FFFF_FF56_7890;
    localparam logic [79:0] P_L3     = 80'hFFFF_FFFF_FFFF_FFFF_F123;
    localparam logic [79:0] P_TUDO_B = 80'hBBBB_BBBB_BBBB_BBBB_BBBB;
    localparam logic [79:0] P_TUDO_E = 80'hEEEE_EEEE_EEEE_EEEE_EEEE;
    localparam logic [79:0] P_VAZIO  = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [79:0] digitos_value;
    logic        digitos_valid;
    logic        prog_req;
    logic        teclado_en;
    logic        destrava;
    logic        senha_erro;
    logic        bloqueado;
    logic        prog_ativo;
    logic [1:0]  tentativas;

    int n_assert = 0;
    int n_fail   = 0;

    verificador_de_senha dut (
        .clk           (clk),
        .rst           (rst),
        .digitos_value (digitos_value),
        .digitos_valid (digitos_valid),
        .prog_req      (prog_req),
        .teclado_en    (teclado_en),
        .destrava      (destrava),
        .senha_erro    (senha_erro),
        .bloqueado     (bloqueado),
        .prog_ativo    (prog_ativo),
        .tentativas    (tentativas)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one entry for a single cycle; returns just after the capture edge.
    task automatic entra(input logic [79:0] v);
        digitos_value = v;
        digitos_valid = 1'b1;
        tick();
        digitos_valid = 1'b0;
        digitos_value = P_VAZIO;
    endtask

    // Number of consecutive samples (from now) with the chosen output high.
    // sel: 0 destrava, 1 senha_erro, 2 bloqueado. Bounded at 2000 cycles.
    task automatic medir(input int sel, output int n);
        logic s;
        n = 0;
        s = (sel == 0) ? destrava : (sel == 1) ? senha_erro : bloqueado;
        while (s === 1'b1 && n < 2000) begin
            n++;
            tick();
            s = (sel == 0) ? destrava : (sel == 1) ? senha_erro : bloqueado;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        digitos_valid = 1'b0;
        digitos_value = P_VAZIO;
        prog_req = 1'b0;
        tick();
        tick();
        n_assert++; if (teclado_en !== 1'b1) begin n_fail++; $display("FAIL reset_teclado_en: observed %b, expected 1", teclado_en); end
        n_assert++; if (destrava !== 1'b0) begin n_fail++; $display("FAIL reset_destrava: observed %b, expected 0", destrava); end
        n_assert++; if (senha_erro !== 1'b0) begin n_fail++; $display("FAIL reset_senha_erro: observed %b, expected 0", senha_erro); end
        n_assert++; if (bloqueado !== 1'b0) begin n_fail++; $display("FAIL reset_bloqueado: observed %b, expected 0", bloqueado); end
        n_assert++; if (prog_ativo !== 1'b0) begin n_fail++; $display("FAIL reset_prog_ativo: observed %b, expected 0", prog_ativo); end
        n_assert++; if (tentativas !== 2'd0) begin n_fail++; $display("FAIL reset_tentativas: observed %0d, expected 0", tentativas); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unlock();
        int n;
        entra(P_1234);
        n_assert++; if (teclado_en !== 1'b0) begin n_fail++; $display("FAIL unlock_teclado_drop: observed %b, expected 0", teclado_en); end
        n_assert++; if (destrava !== 1'b0) begin n_fail++; $display("FAIL unlock_destrava_early: observed %b, expected 0", destrava); end
        tick();
        n_assert++; if (destrava !== 1'b1) begin n_fail++; $display("FAIL unlock_destrava_rise: observed %b, expected 1", destrava); end
        n_assert++; if (tentativas !== 2'd0) begin n_fail++; $display("FAIL unlock_tentativas: observed %0d, expected 0", tentativas); end
        medir(0, n);
        n_assert++; if (n !== 50) begin n_fail++; $display("FAIL unlock_duration: observed %0d, expected 50", n); end
        n_assert++; if (teclado_en !== 1'b1) begin n_fail++; $display("FAIL unlock_teclado_back: observed %b, expected 1", teclado_en); end
    endtask

    task automatic test_lockout();
        int n;
        for (int i = 1; i <= 3; i++) begin
            entra(P_1111);
            tick();
            n_assert++; if (senha_erro !== 1'b1) begin n_fail++; $display("FAIL lock_erro_rise_%0d: observed %b, expected 1", i, senha_erro); end
            n_assert++; if (tentativas !== 2'(i)) begin n_fail++; $display("FAIL lock_tentativas_%0d: observed %0d, expected %0d", i, tentativas, i); end
            medir(1, n);
            n_assert++; if (n !== 50) begin n_fail++; $display("FAIL lock_erro_duration_%0d: observed %0d, expected 50", i, n); end
            if (i < 3) begin
                n_assert++; if (teclado_en !== 1'b1) begin n_fail++; $display("FAIL lock_teclado_%0d: observed %b, expected 1", i, teclado_en); end
            end
        end
        n_assert++; if (bloqueado !== 1'b1) begin n_fail++; $display("FAIL lock_bloqueado_rise: observed %b, expected 1", bloqueado); end
        n_assert++; if (teclado_en !== 1'b0) begin n_fail++; $display("FAIL lock_teclado_off: observed %b, expected 0", teclado_en); end
        medir(2, n);
        n_assert++; if (n !== 1000) begin n_fail++; $display("FAIL lock_duration: observed %0d, expected 1000", n); end
        n_assert++; if (tentativas !== 2'd0) begin n_fail++; $display("FAIL lock_tentativas_clear: observed %0d, expected 0", tentativas); end
        n_assert++; if (teclado_en !== 1'b1) begin n_fail++; $display("FAIL lock_teclado_back: observed %b, expected 1", teclado_en); end
    endtask

    task automatic test_cancel_timeout();
        int n;
        entra(P_TUDO_B);
        tick();
        n_assert++; if ({destrava, senha_erro, bloqueado} !== 3'b000) begin n_fail++; $display("FAIL cancel_outputs: observed %b, expected 000", {destrava, senha_erro, bloqueado}); end
        n_assert++; if (tentativas !== 2'd0) begin n_fail++; $display("FAIL cancel_tentativas: observed %0d, expected 0", tentativas); end
        n_assert++; if (teclado_en !== 1'b1) begin n_fail++; $display("FAIL cancel_teclado: observed %b, expected 1", teclado_en); end
        entra(P_TUDO_E);
        tick();
        n_assert++; if ({destrava, senha_erro, bloqueado} !== 3'b000) begin n_fail++; $display("FAIL timeout_outputs: observed %b, expected 000", {destrava, senha_erro, bloqueado}); end
        n_assert++; if (tentativas !== 2'd0) begin n_fail++; $display("FAIL timeout_tentativas: observed %0d, expected 0", tentativas); end
        entra(P_L3);
        tick();
        n_assert++; if (senha_erro !== 1'b1) begin n_fail++; $display("FAIL short_erro: observed %b, expected 1", senha_erro); end
        n_assert++; if (tentativas !== 2'd1) begin n_fail++; $display("FAIL short_tentativas: observed %0d, expected 1", tentativas); end
        medir(1, n);
        n_assert++; if (n !== 50) begin n_fail++; $display("FAIL short_duration: observed %0d, expected 50", n); end
    endtask

    task automatic test_prog();
        int n;
        prog_req = 1'b1;
        entra(P_MESTRE);
        tick();
        n_assert++; if (prog_ativo !== 1'b1) begin n_fail++; $display("FAIL prog_ativo_rise: observed %b, expected 1", prog_ativo); end
        n_assert++; if (teclado_en !== 1'b1) begin n_fail++; $display("FAIL prog_teclado_on: observed %b, expected 1", teclado_en); end
        entra(P_NOVA);
        n_assert++; if (teclado_en !== 1'b0) begin n_fail++; $display("FAIL prog_teclado_drop: observed %b, expected 0", teclado_en); end
        tick();
        n_assert++; if (destrava !== 1'b1) begin n_fail++; $display("FAIL prog_ack: observed %b, expected 1", destrava); end
        n_assert++; if (prog_ativo !== 1'b0) begin n_fail++; $display("FAIL prog_ativo_clear: observed %b, expected 0", prog_ativo); end
        tick();
        n_assert++; if (destrava !== 1'b0) begin n_fail++; $display("FAIL prog_ack_width: observed %b, expected 0", destrava); end
        prog_req = 1'b0;
        entra(P_NOVA);
        tick();
        n_assert++; if (destrava !== 1'b1) begin n_fail++; $display("FAIL prog_new_unlock: observed %b, expected 1", destrava); end
        medir(0, n);
        n_assert++; if (n !== 50) begin n_fail++; $display("FAIL prog_new_duration: observed %0d, expected 50", n); end
        entra(P_1234);
        tick();
        n_assert++; if (senha_erro !== 1'b1) begin n_fail++; $display("FAIL prog_old_rejected: observed %b, expected 1", senha_erro); end
        n_assert++; if (tentativas !== 2'd1) begin n_fail++; $display("FAIL prog_old_tentativas: observed %0d, expected 1", tentativas); end
        medir(1, n);
    endtask

    task automatic test_prog_invalid();
        prog_req = 1'b1;
        entra(P_MESTRE);
        tick();
        n_assert++; if (prog_ativo !== 1'b1) begin n_fail++; $display("FAIL inval_prog_ativo: observed %b, expected 1", prog_ativo); end
        entra(P_TUDO_B);
        tick();
        n_assert++; if ({destrava, senha_erro} !== 2'b01) begin n_fail++; $display("FAIL inval_nak: observed %b, expected 01", {destrava, senha_erro}); end
        n_assert++; if (tentativas !== 2'd1) begin n_fail++; $display("FAIL inval_tentativas: observed %0d, expected 1", tentativas); end
        tick();
        n_assert++; if (senha_erro !== 1'b0) begin n_fail++; $display("FAIL inval_nak_width: observed %b, expected 0", senha_erro); end
        entra(P_MESTRE);
        tick();
        prog_req = 1'b0;
        tick();
        n_assert++; if (prog_ativo !== 1'b0) begin n_fail++; $display("FAIL abort_prog_ativo: observed %b, expected 0", prog_ativo); end
        n_assert++; if (teclado_en !== 1'b1) begin n_fail++; $display("FAIL abort_teclado: observed %b, expected 1", teclado_en); end
    endtask

    task automatic test_ignore_in_abre();
        int n;
        entra(P_NOVA);
        tick();
        n_assert++; if (destrava !== 1'b1) begin n_fail++; $display("FAIL ign_unlock: observed %b, expected 1", destrava); end
        n_assert++; if (tentativas !== 2'd0) begin n_fail++; $display("FAIL ign_tentativas_clear: observed %0d, expected 0", tentativas); end
        entra(P_1111);
        medir(0, n);
        n_assert++; if (n + 1 !== 50) begin n_fail++; $display("FAIL ign_duration: observed %0d, expected 50", n + 1); end
        tick();
        n_assert++; if ({senha_erro, teclado_en} !== 2'b01) begin n_fail++; $display("FAIL ign_after: observed %b, expected 01", {senha_erro, teclado_en}); end
        n_assert++; if (tentativas !== 2'd0) begin n_fail++; $display("FAIL ign_tentativas: observed %0d, expected 0", tentativas); end
    endtask

    task automatic test_reset_in_bloqueio();
        int n;
        for (int i = 0; i < 3; i++) begin
            entra(P_1111);
            tick();
            medir(1, n);
        end
        repeat (100) tick();
        n_assert++; if (bloqueado !== 1'b1) begin n_fail++; $display("FAIL rstb_locked: observed %b, expected 1", bloqueado); end
        #3;
        rst = 1'b1;
        #1;
        n_assert++; if (bloqueado !== 1'b0) begin n_fail++; $display("FAIL rstb_bloqueado: observed %b, expected 0", bloqueado); end
        n_assert++; if (teclado_en !== 1'b1) begin n_fail++; $display("FAIL rstb_teclado: observed %b, expected 1", teclado_en); end
        n_assert++; if (tentativas !== 2'd0) begin n_fail++; $display("FAIL rstb_tentativas: observed %0d, expected 0", tentativas); end
        n_assert++; if ({destrava, senha_erro, prog_ativo} !== 3'b000) begin n_fail++; $display("FAIL rstb_others: observed %b, expected 000", {destrava, senha_erro, prog_ativo}); end
        tick();
        rst = 1'b0;
        tick();
        entra(P_1234);
        tick();
        n_assert++; if (destrava !== 1'b1) begin n_fail++; $display("FAIL rstb_default_pw: observed %b, expected 1", destrava); end
        medir(0, n);
        n_assert++; if (n !== 50) begin n_fail++; $display("FAIL rstb_default_duration: observed %0d, expected 50", n); end
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_lockout();
        test_cancel_timeout();
        test_prog();
        test_prog_invalid();
        test_ignore_in_abre();
        test_reset_in_bloqueio();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "time limit");
    end

endmodule
